miner_nonce_sched: RTL and testbench

- Bus master that drives the sha256 core's register interface (cs/we/address/write_data/read_data) in place of firmware or LA bit-banging.
- Holds one 16-word message block and substitutes a sweeping nonce into one word of it.
- For each nonce it writes the block, starts the core, polls for the digest, and compares digest word 0 against a target.
- Sits inside the miner control path between the wishbone/LA-loaded configuration and the sha256 instance.

---
 rtl/miner_pkg.sv | 30 +++
 rtl/miner_blk_regs.sv | 35 +++
 rtl/miner_nonce_sched.sv | 237 +++++++++++++++++++++++
 tb/tb_miner_nonce_sched.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared constants and types for the nonce-sweeping sha256 bus master.
// Holds the sha256 core register map, the CTRL/STATUS bit positions,
// the CTRL value that starts a SHA-256 hash, and the scheduler state encoding.
package miner_pkg;

  // sha256 core register map
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h10;
  localparam logic [7:0] ADDR_DIGEST0 = 8'h20;

  // CTRL: bit0 init, bit2 mode (1 = SHA-256). STATUS: bit0 ready, bit1 valid.
  localparam int CTRL_INIT_BIT    = 0;
  localparam int CTRL_MODE_BIT    = 2;
  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_VALID_BIT = 1;

  localparam logic [31:0] CTRL_START = 32'h0000_0005;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    WR_BLK   = 3'd2,
    WR_CTRL  = 3'd3,
    POLL     = 3'd4,
    RD_DIG   = 3'd5,
    DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/miner_blk_regs.sv
// 16-word message block register file.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all words)
//   we, waddr, wdata    single write port
//   raddr, nonce        read index and the nonce to substitute
//   rdata               block[raddr], or nonce when raddr == NONCE_IDX
module miner_blk_regs #(
  parameter int BITS      = 32,
  parameter int NONCE_IDX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [3:0]      waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [3:0]      raddr,
  input  logic [BITS-1:0] nonce,
  output logic [BITS-1:0] rdata
);

  logic [BITS-1:0] mem [16];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The stored word at NONCE_IDX is never sent to the core; the sweeping
  // nonce takes its place.
  assign rdata = (raddr == 4'(NONCE_IDX)) ? nonce : mem[raddr];

endmodule

// File: rtl/miner_nonce_sched.sv
// Nonce sweep scheduler: drives the sha256 core register bus directly.
// For each nonce in [nonce_start .. nonce_end] (wrapping mod 2^32) it waits
// for core ready, writes the 16-word block with the nonce substituted,
// writes CTRL, polls for valid, reads DIGEST0 and compares it to target.
//
// Core bus: a write takes effect at the clock edge ending a cycle that shows
// sha_cs=1, sha_we=1; a read returns sha_read_data combinationally in the
// same cycle that shows sha_cs=1, sha_we=0 and the address. All sha_* outputs
// come straight from flops.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start, stop                      sweep start pulse, abort level
//   blk_we, blk_addr, blk_wdata      block word load (IDLE/DONE only)
//   nonce_start, nonce_end, target   sweep configuration, latched on start
//   sha_cs/we/address/write_data     core register bus outputs
//   sha_read_data                    core read data
//   busy, done, found, aborted       status (done/found/aborted sticky)
//   cur_nonce, found_nonce, found_digest0   sweep results
//   dbg_state                        current scheduler state
module miner_nonce_sched
  import miner_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int NONCE_IDX  = 3,
  parameter int POLL_LIMIT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            blk_we,
  input  logic [3:0]      blk_addr,
  input  logic [BITS-1:0] blk_wdata,
  input  logic [BITS-1:0] nonce_start,
  input  logic [BITS-1:0] nonce_end,
  input  logic [BITS-1:0] target,
  output logic            sha_cs,
  output logic            sha_we,
  output logic [7:0]      sha_address,
  output logic [BITS-1:0] sha_write_data,
  input  logic [BITS-1:0] sha_read_data,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic            aborted,
  output logic [BITS-1:0] cur_nonce,
  output logic [BITS-1:0] found_nonce,
  output logic [BITS-1:0] found_digest0,
  output state_t          dbg_state
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  state_t          state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [BITS-1:0] nonce_d, end_q, end_d, target_q, target_d;
  logic [BITS-1:0] fnonce_d, fd0_d, blk_rdata, wdata_d;
  logic            done_d, found_d, aborted_d;
  logic            cs_d, we_d;
  logic [7:0]      addr_d;
  logic            busy_s, poll_hit;

  assign busy_s    = (state_q != IDLE) && (state_q != DONE);
  assign busy      = busy_s;
  assign dbg_state = state_q;
  assign poll_hit  = (poll_q == PW'(POLL_LIMIT - 1));

  // Read index and nonce follow the *next* state so the registered write
  // data lines up with the registered address.
  miner_blk_regs #(.BITS(BITS), .NONCE_IDX(NONCE_IDX)) u_blk_regs (
    .clk   (clk),
    .rst   (rst),
    .we    (blk_we && !busy_s),
    .waddr (blk_addr),
    .wdata (blk_wdata),
    .raddr (k_d),
    .nonce (nonce_d),
    .rdata (blk_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      k_q            <= '0;
      poll_q         <= '0;
      end_q          <= '0;
      target_q       <= '0;
      cur_nonce      <= '0;
      found_nonce    <= '0;
      found_digest0  <= '0;
      done           <= 1'b0;
      found          <= 1'b0;
      aborted        <= 1'b0;
      sha_cs         <= 1'b0;
      sha_we         <= 1'b0;
      sha_address    <= '0;
      sha_write_data <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      poll_q         <= poll_d;
      end_q          <= end_d;
      target_q       <= target_d;
      cur_nonce      <= nonce_d;
      found_nonce    <= fnonce_d;
      found_digest0  <= fd0_d;
      done           <= done_d;
      found          <= found_d;
      aborted        <= aborted_d;
      sha_cs         <= cs_d;
      sha_we         <= we_d;
      sha_address    <= addr_d;
      sha_write_data <= wdata_d;
    end
  end

  // Next state. Order of priority: stop, then poll timeout, then normal flow.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    poll_d    = poll_q;
    nonce_d   = cur_nonce;
    end_d     = end_q;
    target_d  = target_q;
    fnonce_d  = found_nonce;
    fd0_d     = found_digest0;
    done_d    = done;
    found_d   = found;
    aborted_d = aborted;

    if (busy_s && stop) begin
      state_d   = DONE;
      done_d    = 1'b1;
      aborted_d = 1'b1;
      found_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d   = WAIT_RDY;
            poll_d    = '0;
            nonce_d   = nonce_start;
            end_d     = nonce_end;
            target_d  = target;
            done_d    = 1'b0;
            found_d   = 1'b0;
            aborted_d = 1'b0;
          end
        end
        WAIT_RDY: begin
          if (poll_hit) begin
            state_d   = DONE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
          end else if (sha_read_data[STATUS_READY_BIT]) begin
            state_d = WR_BLK;
            k_d     = '0;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
        WR_BLK: begin
          if (k_q == 4'd15) state_d = WR_CTRL;
          else              k_d     = k_q + 4'd1;
        end
        WR_CTRL: begin
          state_d = POLL;
          poll_d  = '0;
        end
        POLL: begin
          // poll_q == 0 is the cycle right after the CTRL write, where the
          // core can still report the previous hash as valid.
          if (poll_hit) begin
            state_d   = DONE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
          end else if ((poll_q != '0) && sha_read_data[STATUS_VALID_BIT]) begin
            state_d = RD_DIG;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
        RD_DIG: begin
          if (sha_read_data <= target_q) begin
            fnonce_d = cur_nonce;
            fd0_d    = sha_read_data;
            found_d  = 1'b1;
            done_d   = 1'b1;
            state_d  = DONE;
          end else if (cur_nonce == end_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            nonce_d = cur_nonce + BITS'(1);
            poll_d  = '0;
            state_d = WAIT_RDY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus outputs decoded from the state being entered, then registered.
  always_comb begin
    cs_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      WAIT_RDY, POLL: begin
        cs_d   = 1'b1;
        addr_d = ADDR_STATUS;
      end
      WR_BLK: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_BLOCK0 | {4'h0, k_d};
        wdata_d = blk_rdata;
      end
      WR_CTRL: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = BITS'(CTRL_START);
      end
      RD_DIG: begin
        cs_d   = 1'b1;
        addr_d = ADDR_DIGEST0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_miner_nonce_sched.sv
module tb_miner_nonce_sched;
  import miner_pkg::*;

  localparam int NIDX = 0;

  // ---------------- clock / reset ----------------
  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        start, stop, blk_we;
  logic [3:0]  blk_addr;
  logic [31:0] blk_wdata, nonce_start, nonce_end, target;
  logic        sha_cs, sha_we;
  logic [7:0]  sha_address;
  logic [31:0] sha_write_data, sha_read_data;
  logic        busy, done, found, aborted;
  logic [31:0] cur_nonce, found_nonce, found_digest0;
  state_t      dbg_state;

  miner_nonce_sched #(.BITS(32), .NONCE_IDX(NIDX), .POLL_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .blk_we(blk_we), .blk_addr(blk_addr), .blk_wdata(blk_wdata),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .sha_cs(sha_cs), .sha_we(sha_we), .sha_address(sha_address),
    .sha_write_data(sha_write_data), .sha_read_data(sha_read_data),
    .busy(busy), .done(done), .found(found), .aborted(aborted),
    .cur_nonce(cur_nonce), .found_nonce(found_nonce),
    .found_digest0(found_digest0), .dbg_state(dbg_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- SHA-256 reference (digest word 0 only) ----------------
  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sha_d0(input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = 32'h6a09e667; b = 32'hbb67ae85; c = 32'h3c6ef372; d = 32'ha54ff53a;
    e = 32'h510e527f; f = 32'h9b05688c; g = 32'h1f83d9ab; h = 32'h5be0cd19;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return 32'h6a09e667 + a;
  endfunction

  // ---------------- sha256 core stub ----------------
  logic [31:0] core_blk [16];
  logic        core_ready, core_valid, hold_zero;
  logic [2:0]  core_cnt;
  logic [31:0] core_dig0;
  int          cyc;
  logic [7:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q [$];
  logic [31:0] obs_q [$];
  int          ctrl_writes, status_reads;

  initial begin
    core_ready = 1'b1; core_valid = 1'b0; core_cnt = '0; core_dig0 = '0;
    hold_zero = 1'b0; cyc = 0;
    for (int i = 0; i < 16; i++) core_blk[i] = '0;
  end

  function automatic logic [511:0] core_msg();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[511-32*i -: 32] = core_blk[i];
    return m;
  endfunction

  always_comb begin
    sha_read_data = 32'h0;
    if (sha_cs && sha_address == 8'h09)
      sha_read_data = hold_zero ? 32'h0 : {30'd0, core_valid, core_ready};
    else if (sha_cs && sha_address == 8'h20)
      sha_read_data = core_dig0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sha_cs && !sha_we && sha_address == 8'h09) status_reads++;
    if (sha_cs && sha_we) begin
      wr_addr_q.push_back(sha_address);
      wr_data_q.push_back(sha_write_data);
      wr_cyc_q.push_back(cyc);
      if (sha_address[7:4] == 4'h1) core_blk[sha_address[3:0]] <= sha_write_data;
      else if (sha_address == 8'h08 && sha_write_data[0]) begin
        ctrl_writes++;
        obs_q.push_back(core_blk[NIDX]);
        core_ready <= 1'b0;
        core_cnt   <= 3'($urandom_range(1, 5));
      end
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 3'd1;
      if (core_cnt == 3'd1) begin
        core_valid <= 1'b1;
        core_ready <= 1'b1;
        core_dig0  <= sha_d0(core_msg());
      end else begin
        core_valid <= 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] tb_blk [16];
  logic [31:0] exp_q [$];
  logic        m_found;
  logic [31:0] m_fnonce, m_fd0, m_cur;

  function automatic logic [511:0] msg_with_nonce(input logic [31:0] n);
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[511-32*i -: 32] = (i == NIDX) ? n : tb_blk[i];
    return m;
  endfunction

  task automatic model_sweep(input logic [31:0] ns, input logic [31:0] ne, input logic [31:0] tg);
    logic [31:0] n, d;
    exp_q.delete();
    m_found = 1'b0; m_fnonce = '0; m_fd0 = '0;
    n = ns;
    for (int guard = 0; guard < 64; guard++) begin
      exp_q.push_back(n);
      d = sha_d0(msg_with_nonce(n));
      if (d <= tg) begin m_found = 1'b1; m_fnonce = n; m_fd0 = d; break; end
      if (n == ne) break;
      n = n + 32'd1;
    end
    m_cur = n;
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_blk(input int idx, input logic [31:0] d);
    @(negedge clk); blk_we = 1'b1; blk_addr = 4'(idx); blk_wdata = d;
    @(negedge clk); blk_we = 1'b0;
    tb_blk[idx] = d;
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) write_blk(i, 32'h0);
    write_blk(0, 32'h61626380);
    write_blk(15, 32'h00000018);
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) write_blk(i, $urandom);
  endtask

  task automatic kick(input logic [31:0] ns, input logic [31:0] ne, input logic [31:0] tg);
    @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); obs_q.delete();
    ctrl_writes = 0; status_reads = 0;
    nonce_start = ns; nonce_end = ne; target = tg; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, need 1", tag, done, n);
    end
  endtask

  task automatic run_sweep(input string tag, input logic [31:0] ns, input logic [31:0] ne, input logic [31:0] tg);
    kick(ns, ne, tg);
    wait_done(tag);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [141:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs = {sha_cs, sha_we, sha_address, sha_write_data, busy, done, found, aborted,
            cur_nonce, found_nonce, found_digest0};
    tests_run++;
    if (outs !== '0 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h state %0d, need 0 state 0", outs, dbg_state);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) tb_blk[i] = 32'h0;
    // Block must have been cleared by reset: hash with no block loads.
    model_sweep(32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF);
    run_sweep("reset_blk", 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF);
    tests_run++;
    if (found !== 1'b1 || found_digest0 !== m_fd0) begin
      tests_failed++;
      $display("FAIL reset_blk_digest: got found=%b d0=%h, need 1 %h", found, found_digest0, m_fd0);
    end
  endtask

  task automatic test_known_answer();
    load_abc();
    run_sweep("kat", 32'h61626380, 32'h61626380, 32'hFFFF_FFFF);
    tests_run++;
    if (found !== 1'b1 || found_digest0 !== 32'hBA7816BF || found_nonce !== 32'h61626380) begin
      tests_failed++;
      $display("FAIL kat_result: got found=%b d0=%h nonce=%h, need 1 ba7816bf 61626380",
               found, found_digest0, found_nonce);
    end
    tests_run++;
    if (wr_addr_q.size() != 17) begin
      tests_failed++;
      $display("FAIL kat_write_count: got %0d, need 17", wr_addr_q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        tests_run++;
        if (wr_addr_q[k] !== 8'h10 + 8'(k) || wr_data_q[k] !== tb_blk[k] || wr_cyc_q[k] != wr_cyc_q[0] + k) begin
          tests_failed++;
          $display("FAIL kat_blk_write%0d: got addr=%h data=%h cyc+%0d, need %h %h +%0d",
                   k, wr_addr_q[k], wr_data_q[k], wr_cyc_q[k] - wr_cyc_q[0], 8'h10 + 8'(k), tb_blk[k], k);
        end
      end
      tests_run++;
      if (wr_addr_q[16] !== 8'h08 || wr_data_q[16] !== 32'h5 || wr_cyc_q[16] != wr_cyc_q[0] + 16) begin
        tests_failed++;
        $display("FAIL kat_ctrl_write: got addr=%h data=%h cyc+%0d, need 08 00000005 +16",
                 wr_addr_q[16], wr_data_q[16], wr_cyc_q[16] - wr_cyc_q[0]);
      end
    end
  endtask

  task automatic test_sweep_check(input string tag, input logic [31:0] ns, input logic [31:0] ne, input logic [31:0] tg);
    model_sweep(ns, ne, tg);
    run_sweep(tag, ns, ne, tg);
    tests_run++;
    if (found !== m_found || done !== 1'b1 || aborted !== 1'b0 || cur_nonce !== m_cur) begin
      tests_failed++;
      $display("FAIL %s_flags: got found=%b done=%b abort=%b cur=%h, need %b 1 0 %h",
               tag, found, done, aborted, cur_nonce, m_found, m_cur);
    end
    if (m_found) begin
      tests_run++;
      if (found_nonce !== m_fnonce || found_digest0 !== m_fd0) begin
        tests_failed++;
        $display("FAIL %s_found: got nonce=%h d0=%h, need %h %h", tag, found_nonce, found_digest0, m_fnonce, m_fd0);
      end
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s_hash_count: got %0d, need %0d", tag, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL %s_nonce%0d: got %h, need %h", tag, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_miss_and_wrap();
    load_random();
    test_sweep_check("miss", 32'd5, 32'd7, 32'd0);
    tests_run++;
    if (ctrl_writes != 3 || found !== 1'b0 || cur_nonce !== 32'd7) begin
      tests_failed++;
      $display("FAIL miss_summary: got ctrl=%0d found=%b cur=%h, need 3 0 00000007", ctrl_writes, found, cur_nonce);
    end
    test_sweep_check("wrap", 32'hFFFF_FFFE, 32'h0000_0001, 32'd0);
    tests_run++;
    if (ctrl_writes != 4 || obs_q.size() != 4) begin
      tests_failed++;
      $display("FAIL wrap_count: got ctrl=%0d hashes=%0d, need 4 4", ctrl_writes, obs_q.size());
    end else if (obs_q[0] !== 32'hFFFF_FFFE || obs_q[1] !== 32'hFFFF_FFFF || obs_q[2] !== 32'h0 || obs_q[3] !== 32'h1) begin
      tests_failed++;
      $display("FAIL wrap_seq: got %h %h %h %h, need fffffffe ffffffff 00000000 00000001",
               obs_q[0], obs_q[1], obs_q[2], obs_q[3]);
    end
  endtask

  task automatic test_random_sweeps();
    logic [31:0] ns, tg;
    for (int it = 0; it < 4; it++) begin
      load_random();
      ns = $urandom;
      tg = $urandom >> 2;
      test_sweep_check("rand", ns, ns + 32'($urandom_range(0, 4)), tg);
    end
  endtask

  task automatic test_stop();
    int n = 0;
    load_abc();
    kick(32'h61626380, 32'h61626390, 32'h0);
    while (!(sha_cs && sha_we && sha_address == 8'h17) && n < 500) begin @(negedge clk); n++; end
    tests_run++;
    if (n >= 500) begin
      tests_failed++;
      $display("FAIL stop_reach_word7: not seen in %0d cycles", n);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    tests_run++;
    if (sha_cs !== 1'b0 || aborted !== 1'b1 || done !== 1'b1 || found !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_abort: got cs=%b abort=%b done=%b found=%b busy=%b, need 0 1 1 0 0",
               sha_cs, aborted, done, found, busy);
    end
    run_sweep("stop_restart", 32'h61626380, 32'h61626380, 32'hFFFF_FFFF);
    tests_run++;
    if (found !== 1'b1 || aborted !== 1'b0 || found_digest0 !== 32'hBA7816BF) begin
      tests_failed++;
      $display("FAIL stop_restart: got found=%b abort=%b d0=%h, need 1 0 ba7816bf", found, aborted, found_digest0);
    end
  endtask

  task automatic test_ignored_inputs();
    int n = 0;
    logic [31:0] ns;
    load_random();
    ns = $urandom;
    model_sweep(ns, ns, 32'hFFFF_FFFF);
    kick(ns, ns, 32'hFFFF_FFFF);
    while (!(sha_cs && sha_we && sha_address == 8'h13) && n < 500) begin @(negedge clk); n++; end
    blk_we = 1'b1; blk_addr = 4'd5; blk_wdata = ~tb_blk[5];
    start = 1'b1; nonce_start = ns + 32'd9;
    @(negedge clk);
    blk_we = 1'b0; start = 1'b0;
    wait_done("ignored");
    tests_run++;
    if (found_digest0 !== m_fd0 || found_nonce !== ns || ctrl_writes != 1 || wr_addr_q.size() != 17) begin
      tests_failed++;
      $display("FAIL ignored_inputs: got d0=%h nonce=%h ctrl=%0d writes=%0d, need %h %h 1 17",
               found_digest0, found_nonce, ctrl_writes, wr_addr_q.size(), m_fd0, ns);
    end
  endtask

  task automatic test_timeout_and_rst();
    logic [141:0] outs;
    logic [31:0] ns;
    hold_zero = 1'b1;
    run_sweep("timeout", 32'd100, 32'd200, 32'd0);
    tests_run++;
    if (aborted !== 1'b1 || done !== 1'b1 || found !== 1'b0 || status_reads != 8 || ctrl_writes != 0) begin
      tests_failed++;
      $display("FAIL timeout_abort: got abort=%b done=%b found=%b polls=%0d ctrl=%0d, need 1 1 0 8 0",
               aborted, done, found, status_reads, ctrl_writes);
    end
    hold_zero = 1'b0;
    ns = $urandom | 32'h1;
    kick(ns, ns + 32'd9, 32'd0);
    repeat (40) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || cur_nonce === 32'h0) begin
      tests_failed++;
      $display("FAIL rst_pre_busy: got busy=%b cur=%h, need 1 and nonzero", busy, cur_nonce);
    end
    rst = 1'b1;
    @(negedge clk);
    outs = {sha_cs, sha_we, sha_address, sha_write_data, busy, done, found, aborted,
            cur_nonce, found_nonce, found_digest0};
    tests_run++;
    if (outs !== '0 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL rst_mid_sweep: got %h state %0d, need 0 state 0", outs, dbg_state);
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; blk_we = 1'b0; blk_addr = '0; blk_wdata = '0;
    nonce_start = '0; nonce_end = '0; target = '0;
    for (int i = 0; i < 16; i++) tb_blk[i] = '0;
    test_reset();
    test_known_answer();
    test_miss_and_wrap();
    test_random_sweeps();
    test_stop();
    test_ignored_inputs();
    test_timeout_and_rst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
